// File: rtl/i2lbs_pixel_feeder.sv
// rtl/i2lbs_pixel_feeder.sv - serves raster-order frame-buffer pixels to the I2LBS request/receive handshake
module i2lbs_pixel_feeder #(
    parameter int DATA_WIDTH_12                = 12,
    parameter int ADDR_WIDTH                   = 16,
    parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
    parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_start,
    input  logic                     i_pixel_request,
    output logic                     o_pixel_recieve,
    output logic [DATA_WIDTH_12-1:0] o_pixel,
    output logic [DATA_WIDTH_12-1:0] o_ori_x,
    output logic [DATA_WIDTH_12-1:0] o_ori_y,
    output logic                     o_mem_rd,
    output logic [ADDR_WIDTH-1:0]    o_mem_addr,
    input  logic [DATA_WIDTH_12-1:0] i_mem_data,
    output logic                     o_frame_done,
    output logic                     o_busy
);

    localparam logic [DATA_WIDTH_12-1:0] LP_X_LAST = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
    localparam logic [DATA_WIDTH_12-1:0] LP_Y_LAST = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_READ,
        S_CAPTURE,
        S_RESPOND,
        S_RELEASE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [DATA_WIDTH_12-1:0] r_x;
    logic [DATA_WIDTH_12-1:0] r_y;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_mem_rd;
    logic [ADDR_WIDTH-1:0]    r_mem_addr;
    logic [DATA_WIDTH_12-1:0] r_pixel;
    logic [DATA_WIDTH_12-1:0] r_ori_x;
    logic [DATA_WIDTH_12-1:0] r_ori_y;
    logic                     r_recv;
    logic                     r_done;
    logic                     r_busy;
    logic                     w_last;

    assign w_last = (r_x == LP_X_LAST) && (r_y == LP_Y_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next = S_WAIT_REQ;
            S_WAIT_REQ: if (i_pixel_request) w_next = S_READ;
            S_READ:     w_next = S_CAPTURE;
            S_CAPTURE:  w_next = S_RESPOND;
            S_RESPOND:  w_next = w_last ? S_IDLE : S_RELEASE;
            S_RELEASE:  if (!i_pixel_request) w_next = S_WAIT_REQ;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are registered from the next state so each one is high exactly while its state is current.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_pixel    <= '0;
            r_ori_x    <= '0;
            r_ori_y    <= '0;
            r_recv     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_mem_rd <= (w_next == S_READ);
            r_recv   <= (w_next == S_RESPOND);
            r_done   <= (w_next == S_RESPOND) && w_last;
            r_busy   <= (w_next != S_IDLE);
            if (r_state == S_IDLE && i_start) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= '0;
            end
            if (w_next == S_READ) begin
                r_mem_addr <= r_addr;
            end
            if (r_state == S_CAPTURE) begin
                r_pixel <= i_mem_data;
                r_ori_x <= r_x;
                r_ori_y <= r_y;
            end
            // Linear address tracks y*W + x without a multiplier.
            if (r_state == S_RESPOND && !w_last) begin
                r_addr <= r_addr + 1'b1;
                if (r_x == LP_X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign o_pixel_recieve = r_recv;
    assign o_pixel         = r_pixel;
    assign o_ori_x         = r_ori_x;
    assign o_ori_y         = r_ori_y;
    assign o_mem_rd        = r_mem_rd;
    assign o_mem_addr      = r_mem_addr;
    assign o_frame_done    = r_done;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_i2lbs_pixel_feeder.sv
// tb/tb_i2lbs_pixel_feeder.sv - scoreboard bench for i2lbs_pixel_feeder
module tb_i2lbs_pixel_feeder;

    logic        clk_fpga = 1'b0;
    logic        reset_fpga = 1'b0;
    logic        i_start = 1'b0;
    logic        i_pixel_request = 1'b0;
    logic        o_pixel_recieve;
    logic [11:0] o_pixel;
    logic [11:0] o_ori_x;
    logic [11:0] o_ori_y;
    logic        o_mem_rd;
    logic [15:0] o_mem_addr;
    logic [11:0] i_mem_data = '0;
    logic        o_frame_done;
    logic        o_busy;

    typedef struct packed {
        logic        done;
        logic [11:0] pix;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] mem[0:255];
    int          n_checks = 0;
    int          n_fail = 0;
    int          model_x = 0;
    int          model_y = 0;
    logic [11:0] last_pix = '0;

    i2lbs_pixel_feeder dut (
        .clk_fpga        (clk_fpga),
        .reset_fpga      (reset_fpga),
        .i_start         (i_start),
        .i_pixel_request (i_pixel_request),
        .o_pixel_recieve (o_pixel_recieve),
        .o_pixel         (o_pixel),
        .o_ori_x         (o_ori_x),
        .o_ori_y         (o_ori_y),
        .o_mem_rd        (o_mem_rd),
        .o_mem_addr      (o_mem_addr),
        .i_mem_data      (i_mem_data),
        .o_frame_done    (o_frame_done),
        .o_busy          (o_busy)
    );

    always #5 clk_fpga = ~clk_fpga;

    always @(posedge clk_fpga) begin
        if (o_mem_rd) i_mem_data <= mem[o_mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_fpga) begin
        if (o_pixel_recieve) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rcv", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rcv_pixel", o_pixel, e.pix);
                check("rcv_ori_x", o_ori_x, e.x);
                check("rcv_ori_y", o_ori_y, e.y);
                check("rcv_done", o_frame_done, e.done);
            end
        end else if (o_frame_done) begin
            check("done_without_rcv", o_frame_done, 1'b0);
        end
    end

    task automatic start_frame();
        @(negedge clk_fpga);
        i_start = 1'b1;
        @(negedge clk_fpga);
        i_start = 1'b0;
        model_x = 0;
        model_y = 0;
    endtask

    task automatic serve(input int hold, input bit start_mid, input bit start_at_rcv);
        exp_t e;
        bit   got;
        bit   saw_rd;
        e.x    = 12'(model_x);
        e.y    = 12'(model_y);
        e.pix  = mem[model_y * 10 + model_x];
        e.done = (model_x == 9) && (model_y == 9);
        last_pix = e.pix;
        sb.push_back(e);
        @(negedge clk_fpga);
        i_pixel_request = 1'b1;
        got    = 1'b0;
        saw_rd = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk_fpga);
            i_start = (start_mid && n == 0);
            if (o_mem_rd) begin
                saw_rd = 1'b1;
                check("rd_latency", n, 0);
                check("rd_addr", o_mem_addr, model_y * 10 + model_x);
            end
            if (o_pixel_recieve) begin
                got = 1'b1;
                check("rcv_latency", n, 2);
            end
        end
        check("rd_seen", saw_rd, 1'b1);
        check("rcv_seen", got, 1'b1);
        i_start = start_at_rcv;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_fpga);
            i_start = 1'b0;
            check("hold_no_rd", o_mem_rd, 1'b0);
            check("hold_no_rcv", o_pixel_recieve, 1'b0);
            check("hold_pixel", o_pixel, last_pix);
        end
        i_pixel_request = 1'b0;
        @(negedge clk_fpga);
        i_start = 1'b0;
        if (model_x == 9) begin
            model_x = 0;
            model_y++;
        end else begin
            model_x++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'(i);

        repeat (3) @(negedge clk_fpga);
        reset_fpga = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_fpga);
            check("idle_busy", o_busy, 1'b0);
            check("idle_rd", o_mem_rd, 1'b0);
        end
        check("rst_pixel", o_pixel, 12'h0);
        check("rst_ori", {o_ori_x, o_ori_y}, 24'h0);
        check("rst_addr", o_mem_addr, 16'h0);
        check("rst_rcv_done", {o_pixel_recieve, o_frame_done}, 2'b00);
        i_pixel_request = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_fpga);
            check("idle_req_rd", o_mem_rd, 1'b0);
            check("idle_req_rcv", o_pixel_recieve, 1'b0);
        end
        i_pixel_request = 1'b0;

        mem[0] = 12'h0A5;
        start_frame();
        check("busy_after_start", o_busy, 1'b1);
        serve(0, 1'b0, 1'b0);
        check("first_pixel_a5", o_pixel, 12'h0A5);
        @(negedge clk_fpga);
        check("single_pulse", o_pixel_recieve, 1'b0);
        mem[0] = 12'h000;

        reset_fpga = 1'b0;
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        start_frame();
        for (int p = 0; p < 100; p++) begin
            serve((p == 1) ? 5 : 0, p == 3, p == 99);
        end
        check("frame_end_busy", o_busy, 1'b0);
        check("frame_sb_empty", sb.size(), 0);
        i_pixel_request = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_fpga);
            check("post_frame_rd", o_mem_rd, 1'b0);
        end
        i_pixel_request = 1'b0;

        start_frame();
        serve(0, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);
        @(negedge clk_fpga);
        i_pixel_request = 1'b1;
        @(negedge clk_fpga);
        check("pre_rst_rd", o_mem_rd, 1'b1);
        @(posedge clk_fpga);
        #2;
        reset_fpga = 1'b0;
        #1;
        check("arst_busy", o_busy, 1'b0);
        check("arst_rd", o_mem_rd, 1'b0);
        check("arst_addr", o_mem_addr, 16'h0);
        check("arst_pixel", o_pixel, 12'h0);
        check("arst_ori", {o_ori_x, o_ori_y}, 24'h0);
        check("arst_rcv", o_pixel_recieve, 1'b0);
        i_pixel_request = 1'b0;
        sb.delete();
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        start_frame();
        serve(0, 1'b0, 1'b0);
        check("after_rst_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
